// File: rtl/sha_uart_pkg.sv
// rtl/sha_uart_pkg.sv - shared constants and state type for the digest-to-UART egress path
package sha_uart_pkg;

    localparam int SHA256_DIGEST_W = 256;

    localparam logic [7:0] ASCII_0    = 8'h30;
    localparam logic [7:0] ASCII_A_UC = 8'h41;
    localparam logic [7:0] ASCII_A_LC = 8'h61;
    localparam logic [7:0] ASCII_CR   = 8'h0D;
    localparam logic [7:0] ASCII_LF   = 8'h0A;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HEX,
        ST_CR,
        ST_LF
    } stream_state_t;

endpackage

// File: rtl/nibble_to_ascii.sv
// rtl/nibble_to_ascii.sv - combinational 4-bit value to ASCII hex digit
module nibble_to_ascii
    import sha_uart_pkg::*;
#(
    parameter bit UPPERCASE = 1'b0
) (
    input  logic [3:0] nibble,
    output logic [7:0] ascii
);

    always_comb begin
        if (nibble < 4'd10) begin
            ascii = ASCII_0 + {4'b0000, nibble};
        end else begin
            ascii = (UPPERCASE ? ASCII_A_UC : ASCII_A_LC) + {4'b0000, nibble} - 8'd10;
        end
    end

endmodule

// File: rtl/digest_hex_streamer.sv
// rtl/digest_hex_streamer.sv - captures a digest on hash_done and streams it as ASCII hex bytes
module digest_hex_streamer
    import sha_uart_pkg::*;
#(
    parameter int DIGEST_W    = SHA256_DIGEST_W,
    parameter bit UPPERCASE   = 1'b0,
    parameter bit APPEND_CRLF = 1'b1
) (
    input  logic                clk,
    input  logic                master_reset,
    input  logic                hash_done,
    input  logic [DIGEST_W-1:0] hash_out,
    output logic [7:0]          out_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                busy,
    output logic                stream_done,
    output logic                overrun
);

    localparam int NCHAR = DIGEST_W / 4;
    localparam int CNT_W = (NCHAR > 1) ? $clog2(NCHAR) : 1;

    stream_state_t       state, state_d;
    logic [DIGEST_W-1:0] shift_reg, shift_d, shift_next;
    logic [CNT_W-1:0]    char_cnt, cnt_d;
    logic                hash_done_q;
    logic [7:0]          data_d;
    logic                valid_d, done_d, overrun_d;
    logic [7:0]          load_char, next_char;
    logic                rise, xfer, last_char;

    assign rise       = hash_done & ~hash_done_q;
    assign xfer       = out_valid & out_ready;
    assign last_char  = (char_cnt == CNT_W'(NCHAR - 1));
    assign shift_next = shift_reg << 4;
    assign busy       = (state != ST_IDLE);

    nibble_to_ascii #(.UPPERCASE(UPPERCASE)) u_load_char (
        .nibble (hash_out[DIGEST_W-1 -: 4]),
        .ascii  (load_char)
    );

    nibble_to_ascii #(.UPPERCASE(UPPERCASE)) u_next_char (
        .nibble (shift_next[DIGEST_W-1 -: 4]),
        .ascii  (next_char)
    );

    always_comb begin
        state_d   = state;
        shift_d   = shift_reg;
        cnt_d     = char_cnt;
        data_d    = out_data;
        valid_d   = out_valid;
        done_d    = 1'b0;
        overrun_d = overrun | (rise & (state != ST_IDLE));
        case (state)
            ST_IDLE: begin
                if (rise) begin
                    state_d = ST_HEX;
                    shift_d = hash_out;
                    cnt_d   = '0;
                    data_d  = load_char;
                    valid_d = 1'b1;
                end
            end
            ST_HEX: begin
                if (xfer) begin
                    if (!last_char) begin
                        shift_d = shift_next;
                        cnt_d   = char_cnt + 1'b1;
                        data_d  = next_char;
                    end else if (APPEND_CRLF) begin
                        state_d = ST_CR;
                        data_d  = ASCII_CR;
                    end else begin
                        state_d = ST_IDLE;
                        valid_d = 1'b0;
                        done_d  = 1'b1;
                    end
                end
            end
            ST_CR: begin
                if (xfer) begin
                    state_d = ST_LF;
                    data_d  = ASCII_LF;
                end
            end
            ST_LF: begin
                if (xfer) begin
                    state_d = ST_IDLE;
                    valid_d = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    // Reset abandons any stream in flight; a held hash_done is seen as a fresh rise afterwards.
    always_ff @(posedge clk or posedge master_reset) begin
        if (master_reset) begin
            state       <= ST_IDLE;
            shift_reg   <= '0;
            char_cnt    <= '0;
            hash_done_q <= 1'b0;
            out_data    <= 8'h00;
            out_valid   <= 1'b0;
            stream_done <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            state       <= state_d;
            shift_reg   <= shift_d;
            char_cnt    <= cnt_d;
            hash_done_q <= hash_done;
            out_data    <= data_d;
            out_valid   <= valid_d;
            stream_done <= done_d;
            overrun     <= overrun_d;
        end
    end

endmodule

// File: tb/tb_digest_hex_streamer.sv
// tb/tb_digest_hex_streamer.sv - directed self-checking bench for digest_hex_streamer
module tb_digest_hex_streamer;

    localparam int DW = 256;

    logic          clk;
    logic          rst;
    logic          hd  [3];
    logic [DW-1:0] hv  [3];
    logic [7:0]    od  [3];
    logic          ov  [3];
    logic          rd  [3];
    logic          bz  [3];
    logic          sd  [3];
    logic          orr [3];

    int n_vec  = 0;
    int n_miss = 0;

    logic [7:0] exp_q[$];

    digest_hex_streamer #(.DIGEST_W(DW), .UPPERCASE(1'b0), .APPEND_CRLF(1'b1)) dut (
        .clk(clk), .master_reset(rst), .hash_done(hd[0]), .hash_out(hv[0]),
        .out_data(od[0]), .out_valid(ov[0]), .out_ready(rd[0]),
        .busy(bz[0]), .stream_done(sd[0]), .overrun(orr[0])
    );

    digest_hex_streamer #(.DIGEST_W(DW), .UPPERCASE(1'b1), .APPEND_CRLF(1'b1)) dut_uc (
        .clk(clk), .master_reset(rst), .hash_done(hd[1]), .hash_out(hv[1]),
        .out_data(od[1]), .out_valid(ov[1]), .out_ready(rd[1]),
        .busy(bz[1]), .stream_done(sd[1]), .overrun(orr[1])
    );

    digest_hex_streamer #(.DIGEST_W(DW), .UPPERCASE(1'b0), .APPEND_CRLF(1'b0)) dut_nocrlf (
        .clk(clk), .master_reset(rst), .hash_done(hd[2]), .hash_out(hv[2]),
        .out_data(od[2]), .out_valid(ov[2]), .out_ready(rd[2]),
        .busy(bz[2]), .stream_done(sd[2]), .overrun(orr[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Expected bytes are the hex text itself, optionally followed by CR LF.
    task automatic load_expect(input string s, input bit crlf);
        exp_q.delete();
        for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
        if (crlf) begin
            exp_q.push_back(8'h0D);
            exp_q.push_back(8'h0A);
        end
    endtask

    task automatic run_stream(input int k, input bit rnd, input string tag);
        int         got   = 0;
        int         cyc   = 0;
        int         vcyc  = 0;
        bit         pend  = 1'b0;
        bit         first = 1'b1;
        logic [7:0] pdata = 8'h00;
        logic       rdy;
        while (got < exp_q.size() && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            if (first) begin
                check({tag, "_first_valid"}, 32'(ov[k]), 32'd1);
                check({tag, "_busy"}, 32'(bz[k]), 32'd1);
                first = 1'b0;
            end
            if (pend) begin
                check({tag, "_stall_valid"}, 32'(ov[k]), 32'd1);
                check({tag, "_stall_data"}, 32'(od[k]), 32'(pdata));
            end
            if (ov[k]) vcyc++;
            rdy   = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            rd[k] = rdy;
            if (ov[k] && rdy) begin
                check($sformatf("%s_byte%0d", tag, got), 32'(od[k]), 32'(exp_q[got]));
                got++;
            end
            pend  = ov[k] && !rdy;
            pdata = od[k];
        end
        check({tag, "_count"}, 32'(got), 32'(exp_q.size()));
        if (!rnd) check({tag, "_valid_cycles"}, 32'(vcyc), 32'(exp_q.size()));
        rd[k] = 1'b1;
        @(negedge clk);
        check({tag, "_done_pulse"}, 32'(sd[k]), 32'd1);
        check({tag, "_valid_off"}, 32'(ov[k]), 32'd0);
        check({tag, "_busy_off"}, 32'(bz[k]), 32'd0);
        @(negedge clk);
        check({tag, "_done_clear"}, 32'(sd[k]), 32'd0);
    endtask

    string abc_s;
    string uc_s;
    string zero_s;

    initial begin
        abc_s = "ba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad";
        uc_s  = "";
        for (int i = 0; i < 48; i++) uc_s = {uc_s, "F"};
        uc_s = {uc_s, "0123456789ABCDEF"};
        zero_s = "";
        for (int i = 0; i < 64; i++) zero_s = {zero_s, "0"};

        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            hd[i] = 1'b0;
            rd[i] = 1'b1;
        end
        hv[0] = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
        hv[1] = {{48{4'hF}}, 64'h0123456789ABCDEF};
        hv[2] = '0;
        repeat (3) @(negedge clk);
        check("rst_data", 32'(od[0]), 32'h00);
        check("rst_valid", 32'(ov[0]), 32'd0);
        check("rst_busy", 32'(bz[0]), 32'd0);
        check("rst_done", 32'(sd[0]), 32'd0);
        check("rst_overrun", 32'(orr[0]), 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("idle_valid", 32'(ov[0]), 32'd0);

        // 1: "abc" digest, sink always ready
        load_expect(abc_s, 1'b1);
        hd[0] = 1'b1;
        run_stream(0, 1'b0, "abc");

        // 2: same digest, random backpressure
        hd[0] = 1'b0;
        @(negedge clk);
        hd[0] = 1'b1;
        run_stream(0, 1'b1, "abc_rnd");

        // 3: uppercase variant
        load_expect(uc_s, 1'b1);
        hd[1] = 1'b1;
        run_stream(1, 1'b0, "upper");

        // 4: no terminator, zero digest
        load_expect(zero_s, 1'b0);
        hd[2] = 1'b1;
        run_stream(2, 1'b0, "nocrlf");
        repeat (3) @(negedge clk);
        check("nocrlf_quiet", 32'(ov[2]), 32'd0);

        // 5: second rise mid-stream must only flag overrun
        check("pre_overrun", 32'(orr[0]), 32'd0);
        load_expect(abc_s, 1'b1);
        hd[0] = 1'b0;
        @(negedge clk);
        hd[0] = 1'b1;
        fork
            run_stream(0, 1'b0, "ovr");
            begin
                repeat (10) @(negedge clk);
                hd[0] = 1'b0;
                repeat (2) @(negedge clk);
                hd[0] = 1'b1;
            end
        join
        check("overrun_set", 32'(orr[0]), 32'd1);
        repeat (5) @(negedge clk);
        check("no_restart", 32'(bz[0]), 32'd0);
        check("overrun_sticky", 32'(orr[0]), 32'd1);

        // 6: async reset mid-stream, then a fresh stream
        hd[0] = 1'b0;
        hd[1] = 1'b0;
        hd[2] = 1'b0;
        @(negedge clk);
        hd[0] = 1'b1;
        rd[0] = 1'b1;
        repeat (21) @(negedge clk);
        check("mid_valid", 32'(ov[0]), 32'd1);
        check("mid_char20", 32'(od[0]), 32'(exp_q[20]));
        #2;
        rst   = 1'b1;
        hd[0] = 1'b0;
        #1;
        check("async_valid", 32'(ov[0]), 32'd0);
        check("async_busy", 32'(bz[0]), 32'd0);
        check("async_overrun", 32'(orr[0]), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("post_rst_idle", 32'(bz[0]), 32'd0);
        hd[0] = 1'b1;
        run_stream(0, 1'b0, "fresh");
        check("fresh_overrun", 32'(orr[0]), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
